instr_load_encoder: RTL
=======================

Name: instr_load_encoder

Overview:
- Instruction encoder and program loader; the encoding counterpart of the opcode control decoder.
- Accepts symbolic instruction fields over a valid/ready handshake, packs them into 32-bit MIPS words and writes them to sequential instruction-memory addresses from 0.
- Sits between the bench/boot host and the IMEM write port of the unpipelined core.

Parameters:
- ADDR_W, 8, IMEM word-address width; DEPTH = 2**ADDR_W words.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  pulse: clear state and begin a new load
- i_valid  in  1  instruction fields valid
- o_ready  out  1  block can accept fields this cycle
- i_kind  in  4  0 RTYPE, 1 ADDI, 2 ADDIU, 3 LUI, 4 ORI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 J; 10-15 illegal
- i_rs, i_rt, i_rd  in  5 each  register fields
- i_shamt  in  5  shift amount (RTYPE only)
- i_funct  in  6  function code (RTYPE only)
- i_imm  in  16  immediate/offset (I-type)
- i_target  in  26  jump target (J only)
- i_last  in  1  this is the final instruction of the program
- o_imemWe  out  1  IMEM write strobe
- o_imemAddr  out  ADDR_W  IMEM word address
- o_imemData  out  32  encoded instruction
- o_count  out  ADDR_W+1  words written since start
- o_done  out  1  load finished
- o_err  out  1  sticky: illegal i_kind seen
- o_overflow  out  1  sticky: IMEM filled before i_last

Behaviour:
- Reset: state IDLE; o_ready, o_imemWe, o_done, o_err, o_overflow = 0; o_imemAddr, o_imemData, o_count = 0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: o_ready=0; i_start -> LOAD.
- LOAD: o_ready=1. On i_valid&o_ready, latch the encoded word and i_last.
  - Legal kind -> WRITE.
  - Illegal kind: set o_err, write nothing; i_last=1 -> DONE, else stay in LOAD.
- WRITE: o_ready=0; o_imemWe=1 for exactly one cycle with o_imemAddr = current address and o_imemData = latched word.
  - Next cycle: address+1, o_count+1.
  - Latched last -> DONE.
  - Else, if address was DEPTH-1, set o_overflow -> DONE.
  - Else -> LOAD.
- DONE: o_done=1, o_ready=0; hold until i_start.
- Throughput: one word per 2 cycles. Fields are accepted in cycle N, and the write strobe is asserted in cycle N+1.
- Encoding rules:
  - RTYPE: {6'h00, rs, rt, rd, shamt, funct}.
  - ADDI 6'h08, ADDIU 6'h09, ORI 6'h0D, LW 6'h23, SW 6'h2B, BEQ 6'h04, BNE 6'h05: {op, rs, rt, imm}.
  - LUI: {6'h0F, 5'd0, rt, imm}; i_rs is ignored.
  - J: {6'h02, target}.
  - Unused fields are ignored.
- i_start in any state (highest priority after i_rst): address, o_count, o_err, o_overflow, o_done cleared; -> LOAD.
  - Any pending WRITE is suppressed (o_imemWe=0 that cycle).
- i_valid while o_ready=0: ignored; the source holds its fields.
- Reset mid-load: immediate return to reset values; no write strobe in the reset cycle.
- o_imemAddr wraps never: overflow terminates the load instead.

Decomposition:
- Package mips_isa_pkg:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J), shared with the control decoder;
  - kind codes KIND_*;
  - state encoding.
- Sub-module instr_pack: combinational i_kind+fields -> {word[31:0], legal}. The FSM, address counter and handshake stay in the top module.

Test Plan:
- Reset, start, ADDI rs=1 rt=2 imm=16'h0005 with last=1 -> single strobe addr 0 data 32'h20220005; o_count=1; o_done=1.
- Start, then stream RTYPE rs=1 rt=2 rd=3 funct=6'h20, LUI rt=4 imm=16'h1234 (rs=7 given), BEQ rs=1 rt=2 imm=16'hFFFF, J target=26'h10 (last):
  - addresses 0..3;
  - data 00221820, 3C041234, 1022FFFF, 08000010;
  - o_ready low during each WRITE.
- i_kind=4'hC then ORI rt=1 imm=16'h00FF last -> o_err=1; only one write, addr 0 data 340100FF; o_count=1.
- ADDR_W=2, five legal instructions, none last -> four writes (addr 0..3), o_overflow=1, o_done=1, fifth never accepted.
- i_start asserted in a WRITE cycle -> no strobe that cycle; o_count=0, o_err=0; next accepted word written to addr 0.
- i_rst asserted during LOAD with i_valid high -> all outputs at reset values next cycle; no write; i_start required to resume.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes (common with the control decoder),
// symbolic instruction kinds for the loader, and loader state encoding.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] KIND_RTYPE = 4'd0;
    localparam logic [3:0] KIND_ADDI  = 4'd1;
    localparam logic [3:0] KIND_ADDIU = 4'd2;
    localparam logic [3:0] KIND_LUI   = 4'd3;
    localparam logic [3:0] KIND_ORI   = 4'd4;
    localparam logic [3:0] KIND_LW    = 4'd5;
    localparam logic [3:0] KIND_SW    = 4'd6;
    localparam logic [3:0] KIND_BEQ   = 4'd7;
    localparam logic [3:0] KIND_BNE   = 4'd8;
    localparam logic [3:0] KIND_J     = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic instruction kind plus fields -> 32-bit MIPS word.
// o_legal is low for kinds outside the supported set; o_word is then zero.
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        o_word  = 32'd0;
        o_legal = 1'b1;
        case (i_kind)
            KIND_RTYPE: o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
            KIND_ADDI:  o_word = itype(OP_ADDI,  i_rs, i_rt, i_imm);
            KIND_ADDIU: o_word = itype(OP_ADDIU, i_rs, i_rt, i_imm);
            // LUI has no source register; the rs slot is forced to zero.
            KIND_LUI:   o_word = itype(OP_LUI,   5'd0, i_rt, i_imm);
            KIND_ORI:   o_word = itype(OP_ORI,   i_rs, i_rt, i_imm);
            KIND_LW:    o_word = itype(OP_LW,    i_rs, i_rt, i_imm);
            KIND_SW:    o_word = itype(OP_SW,    i_rs, i_rt, i_imm);
            KIND_BEQ:   o_word = itype(OP_BEQ,   i_rs, i_rt, i_imm);
            KIND_BNE:   o_word = itype(OP_BNE,   i_rs, i_rt, i_imm);
            KIND_J:     o_word = {OP_J, i_target};
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_load_encoder.sv
// Program loader: accepts instruction fields over valid/ready, encodes them and
// writes one word per two cycles to sequential IMEM addresses starting at 0.
module instr_load_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_kind,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_shamt,
    input  logic [5:0]        i_funct,
    input  logic [15:0]       i_imm,
    input  logic [25:0]       i_target,
    input  logic              i_last,
    output logic              o_imemWe,
    output logic [ADDR_W-1:0] o_imemAddr,
    output logic [31:0]       o_imemData,
    output logic [ADDR_W:0]   o_count,
    output logic              o_done,
    output logic              o_err,
    output logic              o_overflow
);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              we;

    logic [31:0] pack_word;
    logic        pack_legal;

    instr_pack u_pack (
        .i_kind   (i_kind),
        .i_rs     (i_rs),
        .i_rt     (i_rt),
        .i_rd     (i_rd),
        .i_shamt  (i_shamt),
        .i_funct  (i_funct),
        .i_imm    (i_imm),
        .i_target (i_target),
        .o_word   (pack_word),
        .o_legal  (pack_legal)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= 32'd0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        word_d  = word_q;
        last_d  = last_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (i_start) begin
            // Restart wins over everything, including a pending write.
            state_d = ST_LOAD;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_valid) begin
                        if (pack_legal) begin
                            word_d  = pack_word;
                            last_d  = i_last;
                            state_d = ST_WRITE;
                        end else begin
                            err_d = 1'b1;
                            if (i_last) state_d = ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    we      = 1'b1;
                    count_d = count_q + 1'b1;
                    // Address saturates at the top word so it can never wrap.
                    if (addr_q != '1) addr_d = addr_q + 1'b1;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (addr_q == '1) begin
                        ovf_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_IDLE, ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_ready    = (state_q == ST_LOAD);
    assign o_imemWe   = we && !i_rst;
    assign o_imemAddr = addr_q;
    assign o_imemData = word_q;
    assign o_count    = count_q;
    assign o_done     = (state_q == ST_DONE);
    assign o_err      = err_q;
    assign o_overflow = ovf_q;

endmodule
